// File: rtl/extractor_luma_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : extractor_luma_nxn
//  Brief    : Fetches an NxN luma block plus 2N top / N+1 left neighbours
//             through a fixed-latency frame-memory read port.
//  Revision : 1.0
// ============================================================================
module extractor_luma_nxn #(
    parameter int FRAME_W = 256,
    parameter int FRAME_H = 256,
    parameter int BLK     = 4,
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [11:0]              blk_x,
    input  logic [11:0]              blk_y,
    output logic                     ready,
    output logic                     valid,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [7:0]               rd_data,
    output logic [BLK*BLK*8-1:0]     mb_flat,
    output logic [2*BLK*8-1:0]       top_flat,
    output logic [(BLK+1)*8-1:0]     left_flat
);

    localparam int C_NN    = BLK * BLK;
    localparam int C_LOG_W = $clog2(FRAME_W);
    localparam int C_LOG_B = $clog2(BLK);
    localparam int C_MB_IW = $clog2(C_NN);
    localparam int C_TP_IW = $clog2(2 * BLK);
    localparam int C_LF_IW = $clog2(BLK + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    int                   r_px, r_py;
    int                   r_ntop, r_total, r_iss, r_ret;
    logic [MEM_LAT-1:0]   r_vld;
    logic [7:0]           mb_buf   [C_NN];
    logic [7:0]           top_buf  [2*BLK];
    logic [7:0]           left_buf [BLK+1];
    int                   w_px_in, w_py_in;

    // Top reads stop at the right frame edge; the rest are replicated later.
    function automatic int ntop_of(input int px, input int py);
        if (py == 0) return 0;
        return (FRAME_W - px < 2 * BLK) ? (FRAME_W - px) : (2 * BLK);
    endfunction

    function automatic int nleft_of(input int px, input int py);
        if (px == 0) return 0;
        return (py == 0) ? BLK : (BLK + 1);
    endfunction

    // Maps the idx-th issued read (skipping unavailable entries) to its address.
    function automatic logic [ADDR_W-1:0] addr_of(input int idx, input int px, input int py);
        int nt, ax, ay;
        nt = ntop_of(px, py);
        if (idx < C_NN) begin
            ax = px + (idx % BLK);
            ay = py + (idx / BLK);
        end else if (idx - C_NN < nt) begin
            ax = px + idx - C_NN;
            ay = py - 1;
        end else begin
            ax = px - 1;
            ay = py - 1 + (idx - C_NN - nt) + ((py == 0) ? 1 : 0);
        end
        return ADDR_W'((ay << C_LOG_W) + ax);
    endfunction

    always_comb begin
        w_px_in = int'(blk_x) << C_LOG_B;
        w_py_in = int'(blk_y) << C_LOG_B;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            ready     <= 1'b1;
            valid     <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            mb_flat   <= '0;
            top_flat  <= '0;
            left_flat <= '0;
            r_vld     <= '0;
            r_px      <= 0;
            r_py      <= 0;
            r_ntop    <= 0;
            r_total   <= 0;
            r_iss     <= 0;
            r_ret     <= 0;
        end else begin
            r_vld[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            if (r_vld[MEM_LAT-1]) begin
                r_ret <= r_ret + 1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && ready) begin
                        r_px    <= w_px_in;
                        r_py    <= w_py_in;
                        r_ntop  <= ntop_of(w_px_in, w_py_in);
                        r_total <= C_NN + ntop_of(w_px_in, w_py_in) + nleft_of(w_px_in, w_py_in);
                        r_iss   <= 1;
                        r_ret   <= 0;
                        rd_en   <= 1'b1;
                        rd_addr <= addr_of(0, w_px_in, w_py_in);
                        ready   <= 1'b0;
                        valid   <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_iss < r_total) begin
                        rd_en   <= 1'b1;
                        rd_addr <= addr_of(r_iss, r_px, r_py);
                        r_iss   <= r_iss + 1;
                    end else begin
                        rd_en   <= 1'b0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_vld[MEM_LAT-1] && (r_ret == r_total - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    for (int i = 0; i < C_NN; i++) begin
                        mb_flat[8*i +: 8] <= mb_buf[C_MB_IW'(i)];
                    end
                    for (int j = 0; j < 2 * BLK; j++) begin
                        if (r_py == 0)
                            top_flat[8*j +: 8] <= 8'd128;
                        else if (r_px + j >= FRAME_W)
                            top_flat[8*j +: 8] <= top_buf[C_TP_IW'(FRAME_W - 1 - r_px)];
                        else
                            top_flat[8*j +: 8] <= top_buf[C_TP_IW'(j)];
                    end
                    left_flat[7:0] <= (r_px == 0 || r_py == 0) ? 8'd128 : left_buf[0];
                    for (int l = 1; l <= BLK; l++) begin
                        left_flat[8*l +: 8] <= (r_px == 0) ? 8'd128 : left_buf[C_LF_IW'(l)];
                    end
                    valid   <= 1'b1;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Return slot follows issue order: mb raster, available top, available left.
    always_ff @(posedge clk) begin
        if (r_vld[MEM_LAT-1]) begin
            if (r_ret < C_NN)
                mb_buf[C_MB_IW'(r_ret)] <= rd_data;
            else if (r_ret - C_NN < r_ntop)
                top_buf[C_TP_IW'(r_ret - C_NN)] <= rd_data;
            else
                left_buf[C_LF_IW'(r_ret - C_NN - r_ntop + ((r_py == 0) ? 1 : 0))] <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_extractor_luma_nxn.sv
`default_nettype none
// ============================================================================
//  Module   : tb_extractor_luma_nxn
//  Brief    : Randomised scoreboard bench for extractor_luma_nxn (N=4 and N=16).
//  Revision : 1.0
// ============================================================================
module tb_extractor_luma_nxn;

    localparam int FW = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start4 = 1'b0, start16 = 1'b0;
    logic [11:0] bx = '0, by = '0;

    logic          ready4, valid4, rd_en4;
    logic [15:0]   rd_addr4;
    logic [7:0]    rd_data4;
    logic [127:0]  mb4;
    logic [63:0]   top4;
    logic [39:0]   left4;

    logic          ready16, valid16, rd_en16;
    logic [15:0]   rd_addr16;
    logic [7:0]    rd_data16;
    logic [2047:0] mb16;
    logic [255:0]  top16;
    logic [135:0]  left16;
    logic [7:0]    pipe16 [3];

    extractor_luma_nxn #(.FRAME_W(256), .FRAME_H(256), .BLK(4), .MEM_LAT(1)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .blk_x(bx), .blk_y(by),
        .ready(ready4), .valid(valid4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .mb_flat(mb4), .top_flat(top4), .left_flat(left4)
    );

    extractor_luma_nxn #(.FRAME_W(256), .FRAME_H(256), .BLK(16), .MEM_LAT(3)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .blk_x(bx), .blk_y(by),
        .ready(ready16), .valid(valid16), .rd_en(rd_en16), .rd_addr(rd_addr16),
        .rd_data(rd_data16), .mb_flat(mb16), .top_flat(top16), .left_flat(left16)
    );

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'((x + 3 * y) & 255);
    endfunction

    // Frame memories; data is X outside its return slot so mistimed captures show.
    always @(posedge clk) rd_data4 <= rd_en4 ? pix(int'(rd_addr4) % FW, int'(rd_addr4) / FW) : 8'hxx;
    always @(posedge clk) begin
        pipe16[0] <= rd_en16 ? pix(int'(rd_addr16) % FW, int'(rd_addr16) / FW) : 8'hxx;
        pipe16[1] <= pipe16[0];
        pipe16[2] <= pipe16[1];
    end
    assign rd_data16 = pipe16[2];

    bit            sel;
    logic          s_ready, s_valid, s_rd_en;
    logic [15:0]   s_addr;
    logic [2047:0] s_mb;
    logic [255:0]  s_top;
    logic [135:0]  s_left;

    always_comb begin
        if (sel) begin
            s_ready = ready16; s_valid = valid16; s_rd_en = rd_en16; s_addr = rd_addr16;
            s_mb = mb16; s_top = top16; s_left = left16;
        end else begin
            s_ready = ready4; s_valid = valid4; s_rd_en = rd_en4; s_addr = rd_addr4;
            s_mb = {1920'b0, mb4}; s_top = {192'b0, top4}; s_left = {96'b0, left4};
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [2047:0] exp_mb;
    logic [255:0]  exp_top;
    logic [135:0]  exp_left;
    int            exp_addr [$];
    int            exp_lat;

    // Observations
    int            obs_addr [$];
    int            obs_k [$];
    int            obs_valid_k;
    int            obs_ready_busy;
    logic [2047:0] obs_mb;
    logic [255:0]  obs_top;
    logic [135:0]  obs_left;

    task automatic build_expect(input bit s, input int bxi, input int byi);
        int n, ml, x, y, cx;
        bit avail;
        n = s ? 16 : 4;
        ml = s ? 3 : 1;
        x = bxi * n;
        y = byi * n;
        exp_mb = '0; exp_top = '0; exp_left = '0;
        exp_addr.delete();
        for (int i = 0; i < n * n; i++) begin
            exp_mb[8*i +: 8] = pix(x + i % n, y + i / n);
            exp_addr.push_back((y + i / n) * FW + x + i % n);
        end
        for (int j = 0; j < 2 * n; j++) begin
            if (y == 0) begin
                exp_top[8*j +: 8] = 8'd128;
            end else begin
                cx = x + j;
                if (cx < FW) exp_addr.push_back((y - 1) * FW + cx);
                else cx = FW - 1;
                exp_top[8*j +: 8] = pix(cx, y - 1);
            end
        end
        for (int l = 0; l <= n; l++) begin
            avail = (l == 0) ? (x > 0 && y > 0) : (x > 0);
            if (avail) begin
                exp_addr.push_back((y - 1 + l) * FW + x - 1);
                exp_left[8*l +: 8] = pix(x - 1, y - 1 + l);
            end else begin
                exp_left[8*l +: 8] = 8'd128;
            end
        end
        exp_lat = exp_addr.size() + ml + 1;
    endtask

    function automatic int order_errs();
        int e;
        e = 0;
        if (obs_addr.size() != exp_addr.size()) return -1;
        foreach (exp_addr[i]) if (obs_addr[i] != exp_addr[i] || obs_k[i] != i) e++;
        return e;
    endfunction

    function automatic int first_diff(input logic [2047:0] a, input logic [2047:0] b);
        for (int i = 0; i < 256; i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        return 0;
    endfunction

    // Issues one request and records what the DUT does until valid (bounded).
    task automatic do_request(input bit s, input int bxi, input int byi, input bit pulse);
        sel = s;
        @(negedge clk);
        bx = 12'(bxi);
        by = 12'(byi);
        if (s) start16 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        if (!pulse) begin start4 = 1'b0; start16 = 1'b0; end
        obs_addr.delete(); obs_k.delete();
        obs_valid_k = -1;
        obs_ready_busy = 0;
        for (int k = 0; k < 2000; k++) begin
            if (s_valid) begin obs_valid_k = k; break; end
            if (s_ready) obs_ready_busy++;
            if (s_rd_en) begin obs_addr.push_back(int'(s_addr)); obs_k.push_back(k); end
            @(posedge clk); #1;
        end
        start4 = 1'b0;
        start16 = 1'b0;
        obs_mb = s_mb; obs_top = s_top; obs_left = s_left;
    endtask

    task automatic test_block(input string nm, input bit s, input int bxi, input int byi, input bit hold);
        int d, oe, chg;
        build_expect(s, bxi, byi);
        do_request(s, bxi, byi, 1'b0);
        checks++;
        if (obs_valid_k !== exp_lat) begin
            errors++; $display("FAIL %s latency got %0d exp %0d", nm, obs_valid_k, exp_lat);
        end
        oe = order_errs();
        checks++;
        if (oe !== 0) begin
            errors++; $display("FAIL %s read_seq bad=%0d reads got %0d exp %0d", nm, oe, obs_addr.size(), exp_addr.size());
        end
        checks++;
        if (obs_ready_busy !== 0) begin
            errors++; $display("FAIL %s ready_busy got %0d exp 0", nm, obs_ready_busy);
        end
        checks++;
        if (obs_mb !== exp_mb) begin
            d = first_diff(obs_mb, exp_mb); errors++;
            $display("FAIL %s mb byte %0d got %h exp %h", nm, d, obs_mb[8*d +: 8], exp_mb[8*d +: 8]);
        end
        checks++;
        if (obs_top !== exp_top) begin
            d = first_diff({1792'b0, obs_top}, {1792'b0, exp_top}); errors++;
            $display("FAIL %s top byte %0d got %h exp %h", nm, d, obs_top[8*d +: 8], exp_top[8*d +: 8]);
        end
        checks++;
        if (obs_left !== exp_left) begin
            d = first_diff({1912'b0, obs_left}, {1912'b0, exp_left}); errors++;
            $display("FAIL %s left byte %0d got %h exp %h", nm, d, obs_left[8*d +: 8], exp_left[8*d +: 8]);
        end
        if (hold) begin
            chg = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (s_mb !== obs_mb || s_top !== obs_top || s_left !== obs_left ||
                    s_valid !== 1'b1 || s_ready !== 1'b1 || s_rd_en !== 1'b0) chg++;
            end
            checks++;
            if (chg !== 0) begin
                errors++; $display("FAIL %s hold changed_cycles got %0d exp 0", nm, chg);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready4, valid4, rd_en4, rd_addr4} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++; $display("FAIL reset4_ctrl got %b%b%b %h exp 100 0000", ready4, valid4, rd_en4, rd_addr4);
        end
        checks++;
        if ({mb4, top4, left4} !== '0) begin
            errors++; $display("FAIL reset4_flats got nonzero exp 0 (mb0 %h top0 %h left0 %h)", mb4[7:0], top4[7:0], left4[7:0]);
        end
        checks++;
        if ({ready16, valid16, rd_en16, rd_addr16} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++; $display("FAIL reset16_ctrl got %b%b%b %h exp 100 0000", ready16, valid16, rd_en16, rd_addr16);
        end
        checks++;
        if ({mb16, top16, left16} !== '0) begin
            errors++; $display("FAIL reset16_flats got nonzero exp 0 (mb0 %h top0 %h left0 %h)", mb16[7:0], top16[7:0], left16[7:0]);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_named_cases();
        test_block("origin", 1'b0, 0, 0, 1'b1);
        test_block("interior", 1'b0, 5, 7, 1'b1);
        test_block("right_edge", 1'b0, 63, 2, 1'b1);
        test_block("top_edge", 1'b0, 9, 0, 1'b0);
        test_block("left_edge", 1'b0, 0, 11, 1'b0);
        test_block("blk16", 1'b1, 1, 1, 1'b1);
        test_block("blk16_right", 1'b1, 15, 3, 1'b0);
    endtask

    task automatic test_start_during_busy();
        int extra;
        build_expect(1'b0, 5, 7);
        do_request(1'b0, 5, 7, 1'b1);
        checks++;
        if (obs_valid_k !== exp_lat) begin
            errors++; $display("FAIL busy_start latency got %0d exp %0d", obs_valid_k, exp_lat);
        end
        checks++;
        if (obs_addr.size() !== exp_addr.size()) begin
            errors++; $display("FAIL busy_start reads got %0d exp %0d", obs_addr.size(), exp_addr.size());
        end
        checks++;
        if (obs_ready_busy !== 0) begin
            errors++; $display("FAIL busy_start ready_busy got %0d exp 0", obs_ready_busy);
        end
        checks++;
        if ({obs_mb, obs_top, obs_left} !== {exp_mb, exp_top, exp_left}) begin
            errors++; $display("FAIL busy_start data mb0 got %h exp %h", obs_mb[7:0], exp_mb[7:0]);
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (rd_en4 !== 1'b0 || valid4 !== 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL busy_start extra_activity got %0d exp 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int act;
        sel = 1'b0;
        @(negedge clk);
        bx = 12'd5; by = 12'd7; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rd_en4, valid4, ready4} !== 3'b001) begin
            errors++; $display("FAIL midop_reset rd_en/valid/ready got %b%b%b exp 001", rd_en4, valid4, ready4);
        end
        checks++;
        if ({mb4, top4, left4} !== '0) begin
            errors++; $display("FAIL midop_reset flats got mb0 %h exp 00", mb4[7:0]);
        end
        reset = 1'b0;
        act = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rd_en4 !== 1'b0 || valid4 !== 1'b0 || ready4 !== 1'b1) act++;
        end
        checks++;
        if (act !== 0) begin
            errors++; $display("FAIL midop_idle activity got %0d exp 0", act);
        end
        test_block("after_reset", 1'b0, 5, 7, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_block("b2b_a", 1'b0, 12, 30, 1'b0);
        test_block("b2b_b", 1'b0, 40, 1, 1'b0);
        test_block("b2b_c", 1'b0, 62, 63, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_block("rand4", 1'b0, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            test_block("rand16", 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_named_cases();
        test_start_during_busy();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
